// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the two-client memory arbiter.
package mem_arb_pkg;

    localparam int unsigned ADDR_W = 28;
    localparam int unsigned DATA_W = 128;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2
    } arb_state_t;

    localparam logic CL_I = 1'b0;
    localparam logic CL_D = 1'b1;

    // Grant state that serves the given client id.
    function automatic arb_state_t gnt_state(input logic id);
        return (id == CL_D) ? GNT_D : GNT_I;
    endfunction

endpackage

// File: rtl/mem_arbiter_rr_pick2.sv
// Combinational two-requester round-robin picker: on a tie the client
// that was not granted last wins.
module rr_pick2
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic       gnt_valid,
    output logic       gnt_id
);

    // Pick the single requester, or the one not served last on a tie.
    always_comb begin
        gnt_valid = |req;
        gnt_id    = CL_I;
        case (req)
            2'b01:   gnt_id = CL_I;
            2'b10:   gnt_id = CL_D;
            2'b11:   gnt_id = ~last;
            default: gnt_id = CL_I;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-client memory arbiter: routes one whole I-cache or D-cache
// transaction at a time to the shared memory port, round-robin on ties.
module mem_arbiter #(
    parameter int unsigned ADDR_W = mem_arb_pkg::ADDR_W,
    parameter int unsigned DATA_W = mem_arb_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              proc_reset,

    input  logic              i_read,
    input  logic              i_write,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_ready,

    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ready,

    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
);

    import mem_arb_pkg::*;

    arb_state_t state_q, state_d;
    logic       last_q, last_d;

    logic       i_req, d_req;
    logic       gnt_valid;
    logic       gnt_id;

    assign i_req = i_read | i_write;
    assign d_req = d_read | d_write;

    rr_pick2 u_pick (
        .req       ({d_req, i_req}),
        .last      (last_q),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id)
    );

    // State and last-granted registers; last resets to I so D wins the first tie.
    always_ff @(posedge clk) begin
        if (proc_reset) begin
            state_q <= IDLE;
            last_q  <= CL_I;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

    // Next state: grant from IDLE, release on mem_ready or an abandoned request.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (gnt_valid) begin
                    state_d = gnt_state(gnt_id);
                end
            end
            GNT_I: begin
                if (mem_ready) begin
                    state_d = IDLE;
                    last_d  = CL_I;
                end else if (!i_req) begin
                    state_d = IDLE;
                end
            end
            GNT_D: begin
                if (mem_ready) begin
                    state_d = IDLE;
                    last_d  = CL_D;
                end else if (!d_req) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output mux: the granted client's request passes straight to memory.
    always_comb begin
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        i_ready   = 1'b0;
        d_ready   = 1'b0;
        case (state_q)
            GNT_I: begin
                mem_read  = i_read;
                mem_write = i_write;
                mem_addr  = i_addr;
                mem_wdata = i_wdata;
                i_ready   = mem_ready;
            end
            GNT_D: begin
                mem_read  = d_read;
                mem_write = d_write;
                mem_addr  = d_addr;
                mem_wdata = d_wdata;
                d_ready   = mem_ready;
            end
            default: ;
        endcase
    end

    // Read data is broadcast; each cache qualifies it with its own ready.
    assign i_rdata = mem_rdata;
    assign d_rdata = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus pushes the expected memory-side
// transaction order, a monitor pops and checks each transaction and ready.
module tb_mem_arbiter;

    import mem_arb_pkg::*;

    localparam int unsigned AW = 28;
    localparam int unsigned DW = 128;

    logic          clk = 1'b0;
    logic          proc_reset;
    logic          i_read, i_write, d_read, d_write;
    logic [AW-1:0] i_addr, d_addr;
    logic [DW-1:0] i_wdata, d_wdata;
    logic [DW-1:0] i_rdata, d_rdata;
    logic          i_ready, d_ready;
    logic          mem_read, mem_write;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
    logic          mem_ready = 1'b0;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk        (clk),
        .proc_reset (proc_reset),
        .i_read     (i_read),
        .i_write    (i_write),
        .i_addr     (i_addr),
        .i_wdata    (i_wdata),
        .i_rdata    (i_rdata),
        .i_ready    (i_ready),
        .d_read     (d_read),
        .d_write    (d_write),
        .d_addr     (d_addr),
        .d_wdata    (d_wdata),
        .d_rdata    (d_rdata),
        .d_ready    (d_ready),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready)
    );

    typedef struct {
        bit            cl;
        bit            rd;
        bit            wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        bit            chk_gap;
    } txn_t;

    txn_t exp_q[$];
    txn_t i_list[$];
    txn_t d_list[$];

    int checks   = 0;
    int failures = 0;

    localparam logic [DW-1:0] RST_PAT = {4{32'hDEADBEEF}};

    function automatic logic [DW-1:0] rdata_of(input logic [AW-1:0] a);
        if (a == 28'h0000010) return {16{8'hA5}};
        return {4{32'h5A5A5A5A ^ {4'h0, a}}};
    endfunction

    function automatic logic [DW-1:0] wdata_of(input bit cl, input logic [AW-1:0] a);
        return {4{32'hC3C3C3C3 ^ {3'h0, cl, a}}};
    endfunction

    function automatic txn_t mk(input bit cl, input bit wr, input logic [AW-1:0] a, input bit g);
        txn_t t;
        t.cl = cl; t.rd = !wr; t.wr = wr; t.addr = a;
        t.wdata = wdata_of(cl, a); t.chk_gap = g;
        return t;
    endfunction

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
        end
    endtask

    // Memory model: answers each request after mem_lat cycles, one-cycle ready.
    bit            mem_en = 1'b0;
    bit            man_ready = 1'b0;
    logic [DW-1:0] man_rdata = '0;
    int            mem_lat = 5;
    bit            busy = 1'b0;
    int            cnt = 0;

    always @(posedge clk) begin
        #2;
        if (!mem_en) begin
            busy = 1'b0;
            cnt = 0;
            mem_ready = man_ready;
            mem_rdata = man_rdata;
        end else if (mem_ready) begin
            mem_ready = 1'b0;
            busy = 1'b0;
        end else if (!busy && (mem_read || mem_write)) begin
            busy = 1'b1;
            cnt = 1;
        end else if (busy) begin
            cnt++;
            if (cnt >= mem_lat) begin
                mem_ready = 1'b1;
                mem_rdata = rdata_of(mem_addr);
            end
        end
    end

    // Monitor: pops the expected transaction when memory first sees a request.
    bit   in_txn = 1'b0;
    bit   prev_ready = 1'b0;
    int   gap = 100;
    txn_t cur;

    always @(negedge clk) begin
        gap++;
        if (proc_reset) begin
            in_txn = 1'b0;
            prev_ready = 1'b0;
        end else begin
            if (prev_ready)
                check("bubble_after_ready", DW'(mem_read | mem_write), DW'(0));
            if (!in_txn && (mem_read || mem_write)) begin
                in_txn = 1'b1;
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_txn actual_addr=%0h required=none", mem_addr);
                    cur = mk(CL_I, 1'b0, '0, 1'b0);
                end else begin
                    cur = exp_q.pop_front();
                    check("txn_type", DW'({mem_read, mem_write}), DW'({cur.rd, cur.wr}));
                    check("txn_addr", DW'(mem_addr), DW'(cur.addr));
                    check("txn_wdata", mem_wdata, cur.wdata);
                    if (cur.chk_gap) check("grant_gap", DW'(gap), DW'(2));
                end
            end else if (in_txn && !(mem_read || mem_write)) begin
                in_txn = 1'b0;
            end
            if (mem_ready) begin
                if (in_txn) begin
                    check("i_ready", DW'(i_ready), DW'(cur.cl == CL_I));
                    check("d_ready", DW'(d_ready), DW'(cur.cl == CL_D));
                    check("rdata", (cur.cl == CL_D) ? d_rdata : i_rdata, rdata_of(cur.addr));
                end else begin
                    check("stray_ready", DW'({i_ready, d_ready}), DW'(0));
                end
                gap = 0;
                prev_ready = 1'b1;
            end else begin
                check("no_ready_without_mem", DW'({i_ready, d_ready}), DW'(0));
                prev_ready = 1'b0;
            end
        end
    end

    task automatic set_req(input bit cl, input txn_t t);
        if (cl == CL_D) begin
            d_read = t.rd; d_write = t.wr; d_addr = t.addr; d_wdata = t.wdata;
        end else begin
            i_read = t.rd; i_write = t.wr; i_addr = t.addr; i_wdata = t.wdata;
        end
    endtask

    task automatic clear_req(input bit cl);
        if (cl == CL_D) begin
            d_read = 1'b0; d_write = 1'b0;
        end else begin
            i_read = 1'b0; i_write = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Client driver: holds each request until its ready, then presents the next.
    task automatic run_client(input bit cl);
        txn_t t;
        bit   got;
        int   left;
        left = (cl == CL_D) ? d_list.size() : i_list.size();
        while (left > 0) begin
            if (cl == CL_D) t = d_list.pop_front();
            else            t = i_list.pop_front();
            set_req(cl, t);
            got = 1'b0;
            for (int k = 0; k < 200 && !got; k++) begin
                @(negedge clk);
                if ((cl == CL_D) ? d_ready : i_ready) got = 1'b1;
            end
            checks++;
            if (!got) begin
                failures++;
                $display("FAIL ready_timeout client=%0d addr=%0h actual=none required=ready", cl, t.addr);
            end
            @(posedge clk);
            #1;
            left = (cl == CL_D) ? d_list.size() : i_list.size();
        end
        clear_req(cl);
    endtask

    task automatic do_reset();
        proc_reset = 1'b1;
        idle(1);
        proc_reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "global timeout");
    end

    initial begin
        proc_reset = 1'b1;
        i_read = 1'b0; i_write = 1'b0; i_addr = '0; i_wdata = '0;
        d_read = 1'b0; d_write = 1'b0; d_addr = '0; d_wdata = '0;
        man_rdata = RST_PAT;
        man_ready = 1'b1;

        // Reset state: outputs quiet even with mem_ready high, rdata broadcast.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_mem_rw", DW'({mem_read, mem_write}), DW'(0));
        check("rst_mem_addr", DW'(mem_addr), DW'(0));
        check("rst_mem_wdata", mem_wdata, DW'(0));
        check("rst_ready", DW'({i_ready, d_ready}), DW'(0));
        check("rst_i_rdata", i_rdata, RST_PAT);
        check("rst_d_rdata", d_rdata, RST_PAT);
        @(posedge clk);
        #1;
        proc_reset = 1'b0;
        man_ready = 1'b0;
        mem_en = 1'b1;
        idle(2);

        // Single I read with latency check at memory.
        exp_q.push_back(mk(CL_I, 1'b0, 28'h0000010, 1'b0));
        i_list.push_back(mk(CL_I, 1'b0, 28'h0000010, 1'b0));
        fork
            run_client(CL_I);
            begin
                @(negedge clk);
                check("t_not_yet_at_mem", DW'(mem_read), DW'(0));
                @(negedge clk);
                check("t1_mem_read", DW'(mem_read), DW'(1));
                check("t1_mem_addr", DW'(mem_addr), DW'(28'h0000010));
            end
        join
        idle(2);

        // Simultaneous requests after reset: D first, I at r+2.
        do_reset();
        exp_q.push_back(mk(CL_D, 1'b0, 28'h0001000, 1'b0));
        exp_q.push_back(mk(CL_I, 1'b0, 28'h0002000, 1'b1));
        d_list.push_back(mk(CL_D, 1'b0, 28'h0001000, 1'b0));
        i_list.push_back(mk(CL_I, 1'b0, 28'h0002000, 1'b0));
        fork
            run_client(CL_I);
            run_client(CL_D);
        join
        idle(2);

        // Alternation over six back-to-back transactions.
        for (int k = 0; k < 3; k++) begin
            exp_q.push_back(mk(CL_D, 1'b0, AW'(28'h0001100 + 16 * k), k != 0));
            exp_q.push_back(mk(CL_I, 1'b0, AW'(28'h0002100 + 16 * k), 1'b1));
            d_list.push_back(mk(CL_D, 1'b0, AW'(28'h0001100 + 16 * k), 1'b0));
            i_list.push_back(mk(CL_I, 1'b0, AW'(28'h0002100 + 16 * k), 1'b0));
        end
        fork
            run_client(CL_I);
            run_client(CL_D);
        join
        idle(2);

        // D dirty miss while I waits: D write, I read, D read.
        exp_q.push_back(mk(CL_D, 1'b1, 28'h0000020, 1'b0));
        exp_q.push_back(mk(CL_I, 1'b0, 28'h0002200, 1'b1));
        exp_q.push_back(mk(CL_D, 1'b0, 28'h0000040, 1'b1));
        d_list.push_back(mk(CL_D, 1'b1, 28'h0000020, 1'b0));
        d_list.push_back(mk(CL_D, 1'b0, 28'h0000040, 1'b0));
        i_list.push_back(mk(CL_I, 1'b0, 28'h0002200, 1'b0));
        fork
            run_client(CL_I);
            run_client(CL_D);
        join
        idle(2);

        // Reset mid-transaction during GNT_I, then a stray mem_ready.
        mem_en = 1'b0;
        man_ready = 1'b0;
        exp_q.push_back(mk(CL_I, 1'b0, 28'h0002300, 1'b0));
        set_req(CL_I, mk(CL_I, 1'b0, 28'h0002300, 1'b0));
        idle(3);
        proc_reset = 1'b1;
        idle(1);
        proc_reset = 1'b0;
        clear_req(CL_I);
        man_ready = 1'b1;
        @(negedge clk);
        check("rst_mid_mem_read", DW'(mem_read), DW'(0));
        check("rst_mid_i_ready", DW'(i_ready), DW'(0));
        idle(1);
        man_ready = 1'b0;
        idle(2);

        // Protocol violation: D drops its request; last stays I so D wins again.
        exp_q.push_back(mk(CL_D, 1'b0, 28'h0001300, 1'b0));
        exp_q.push_back(mk(CL_D, 1'b0, 28'h0001310, 1'b0));
        exp_q.push_back(mk(CL_I, 1'b0, 28'h0002310, 1'b1));
        set_req(CL_D, mk(CL_D, 1'b0, 28'h0001300, 1'b0));
        idle(3);
        clear_req(CL_D);
        idle(1);
        mem_en = 1'b1;
        d_list.push_back(mk(CL_D, 1'b0, 28'h0001310, 1'b0));
        i_list.push_back(mk(CL_I, 1'b0, 28'h0002310, 1'b0));
        fork
            run_client(CL_I);
            run_client(CL_D);
            begin
                @(negedge clk);
                check("viol_idle_mem_read", DW'(mem_read), DW'(0));
            end
        join
        idle(3);

        check("scoreboard_empty", DW'(exp_q.size()), DW'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
